// File: rtl/jtcps1_gfx_pkg.sv
// Shared constants for the table-driven CPS1 graphics ROM mapper: layer codes,
// config field selectors and a default range table for boot-time loading.
package jtcps1_gfx_pkg;

  localparam logic [2:0] LAYER_OBJ     = 3'd0;
  localparam logic [2:0] LAYER_SCROLL1 = 3'd1;
  localparam logic [2:0] LAYER_SCROLL2 = 3'd2;
  localparam logic [2:0] LAYER_SCROLL3 = 3'd3;
  localparam logic [2:0] LAYER_STAR    = 3'd4;
  localparam int         NUM_LAYERS    = 5;

  localparam logic [1:0] FLD_START = 2'd0;
  localparam logic [1:0] FLD_END   = 2'd1;
  localparam logic [1:0] FLD_BASE  = 2'd2;
  localparam logic [1:0] FLD_MASK  = 2'd3;

  // Storage is always sized for the largest legal table; unused rows stay cleared.
  localparam int MAX_ENTRIES = 8;

  localparam int DEF_ENTRIES = 4;
  localparam logic [15:0] DEF_START [DEF_ENTRIES] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
  localparam logic [15:0] DEF_END   [DEF_ENTRIES] = '{16'h7FFF, 16'h3FFF, 16'h1FFF, 16'h03FF};
  localparam logic [21:0] DEF_BASE  [DEF_ENTRIES] = '{22'h000000, 22'h040000, 22'h060000, 22'h070000};
  localparam logic [5:0]  DEF_MASK  [DEF_ENTRIES] = '{6'h21, 6'h22, 6'h2C, 6'h30};

  function automatic logic [5:0] mask_word(input logic en, input logic [4:0] layers);
    return {en, layers};
  endfunction

endpackage

// File: rtl/jtcps1_gfx_mapper_tbl_if.sv
// Request/response and configuration bus of the table-driven graphics mapper.
interface jtcps1_gfx_mapper_tbl_if #(
  parameter int CW = 16,
  parameter int AW = 22,
  parameter int LW = 3
);
  logic          cfg_we;
  logic [2:0]    cfg_idx;
  logic [1:0]    cfg_fld;
  logic [AW-1:0] cfg_data;

  logic          req_valid;
  logic          req_ready;
  logic [LW-1:0] req_layer;
  logic [CW-1:0] req_code;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [AW-1:0] rsp_addr;
  logic          rsp_hit;
  logic [2:0]    rsp_entry;

  modport master (
    output cfg_we, cfg_idx, cfg_fld, cfg_data,
    output req_valid, req_layer, req_code, rsp_ready,
    input  req_ready, rsp_valid, rsp_addr, rsp_hit, rsp_entry
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_fld, cfg_data,
    input  req_valid, req_layer, req_code, rsp_ready,
    output req_ready, rsp_valid, rsp_addr, rsp_hit, rsp_entry
  );
endinterface

// File: rtl/jtcps1_gfx_mapper_match.sv
// Parallel range compare of every table entry plus a lowest-index-wins
// priority encoder.
module jtcps1_gfx_mapper_match
  import jtcps1_gfx_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int CW      = 16,
  parameter int LW      = 3
) (
  input  logic [MAX_ENTRIES-1:0] i_en,
  input  logic [4:0]             i_mask  [MAX_ENTRIES],
  input  logic [CW-1:0]          i_start [MAX_ENTRIES],
  input  logic [CW-1:0]          i_end   [MAX_ENTRIES],
  input  logic [LW-1:0]          i_layer,
  input  logic [CW-1:0]          i_code,
  output logic                   o_hit,
  output logic [2:0]             o_idx
);

  logic [4:0]             w_layer_oh;
  logic [MAX_ENTRIES-1:0] w_match;

  // Layer codes beyond STAR decode to no bit, so they can never match.
  always_comb begin
    w_layer_oh = '0;
    for (int l = 0; l < NUM_LAYERS; l++)
      w_layer_oh[l] = (i_layer == LW'(l));
  end

  always_comb begin
    w_match = '0;
    for (int i = 0; i < MAX_ENTRIES; i++)
      w_match[i] = (i < ENTRIES) && i_en[i] && (|(i_mask[i] & w_layer_oh)) &&
                   (i_code >= i_start[i]) && (i_code <= i_end[i]);
  end

  always_comb begin
    o_hit = 1'b0;
    o_idx = 3'd0;
    for (int i = MAX_ENTRIES - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        o_hit = 1'b1;
        o_idx = 3'(i);
      end
    end
  end

endmodule

// File: rtl/jtcps1_gfx_mapper_tbl.sv
// Programmable CPS1 graphics ROM mapper: range table lookup followed by a
// two-stage valid/ready pipeline producing base + (code - start).
module jtcps1_gfx_mapper_tbl
  import jtcps1_gfx_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int CW      = 16,
  parameter int AW      = 22,
  parameter int LW      = 3
) (
  input logic                     clk,
  input logic                     rst_n,
  jtcps1_gfx_mapper_tbl_if.slave  bus
);

  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] base,
                                             input logic [CW-1:0] off);
    return base + AW'(off);
  endfunction

  logic [MAX_ENTRIES-1:0] r_en;
  logic [4:0]             r_mask  [MAX_ENTRIES];
  logic [CW-1:0]          r_start [MAX_ENTRIES];
  logic [CW-1:0]          r_end   [MAX_ENTRIES];
  logic [AW-1:0]          r_base  [MAX_ENTRIES];

  logic          w_hit;
  logic [2:0]    w_idx;
  logic          w_adv_p2;
  logic          w_req_ready;
  logic          w_acc;

  logic          r_vld_p1;
  logic          r_hit_p1;
  logic [2:0]    r_idx_p1;
  logic [CW-1:0] r_off_p1;
  logic [AW-1:0] r_base_p1;

  logic          r_vld_p2;
  logic          r_hit_p2;
  logic [2:0]    r_idx_p2;
  logic [AW-1:0] r_addr_p2;

  // Rows at or above ENTRIES are never written, so they stay cleared.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_ENTRIES; i++) begin
        r_en[i]    <= 1'b0;
        r_mask[i]  <= '0;
        r_start[i] <= '0;
        r_end[i]   <= '0;
        r_base[i]  <= '0;
      end
    end else if (bus.cfg_we && (int'(bus.cfg_idx) < ENTRIES)) begin
      case (bus.cfg_fld)
        FLD_START: r_start[bus.cfg_idx] <= bus.cfg_data[CW-1:0];
        FLD_END:   r_end[bus.cfg_idx]   <= bus.cfg_data[CW-1:0];
        FLD_BASE:  r_base[bus.cfg_idx]  <= bus.cfg_data;
        default: begin
          r_en[bus.cfg_idx]   <= bus.cfg_data[5];
          r_mask[bus.cfg_idx] <= bus.cfg_data[4:0];
        end
      endcase
    end
  end

  jtcps1_gfx_mapper_match #(
    .ENTRIES (ENTRIES),
    .CW      (CW),
    .LW      (LW)
  ) u_match (
    .i_en    (r_en),
    .i_mask  (r_mask),
    .i_start (r_start),
    .i_end   (r_end),
    .i_layer (bus.req_layer),
    .i_code  (bus.req_code),
    .o_hit   (w_hit),
    .o_idx   (w_idx)
  );

  assign w_adv_p2    = !r_vld_p2 || bus.rsp_ready;
  assign w_req_ready = !r_vld_p1 || w_adv_p2;
  assign w_acc       = bus.req_valid && w_req_ready;

  // ---- stage p1: match result snapshotted from the table at acceptance ----
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_vld_p1 <= 1'b0;
    else if (w_acc)
      r_vld_p1 <= 1'b1;
    else if (w_adv_p2)
      r_vld_p1 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_hit_p1  <= w_hit;
      r_idx_p1  <= w_idx;
      r_off_p1  <= bus.req_code - r_start[w_idx];
      r_base_p1 <= r_base[w_idx];
    end
  end

  // ---- stage p2: output register, held while the consumer stalls ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p2  <= 1'b0;
      r_hit_p2  <= 1'b0;
      r_idx_p2  <= 3'd0;
      r_addr_p2 <= '0;
    end else if (w_adv_p2) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_hit_p2  <= r_hit_p1;
        r_idx_p2  <= r_hit_p1 ? r_idx_p1 : 3'd0;
        r_addr_p2 <= r_hit_p1 ? wrap_add(r_base_p1, r_off_p1) : '0;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_vld_p2;
  assign bus.rsp_hit   = r_hit_p2;
  assign bus.rsp_entry = r_idx_p2;
  assign bus.rsp_addr  = r_addr_p2;

endmodule

// File: tb/tb_jtcps1_gfx_mapper_tbl.sv
// Directed bench for the table-driven graphics mapper: vector table plus
// hand sequences for backpressure, write snapshot and mid-flight reset.
module tb_jtcps1_gfx_mapper_tbl;
  import jtcps1_gfx_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  jtcps1_gfx_mapper_tbl_if #(.CW(16), .AW(22), .LW(3)) bus ();

  jtcps1_gfx_mapper_tbl #(
    .ENTRIES (4),
    .CW      (16),
    .AW      (22),
    .LW      (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  layer;
    logic [15:0] code;
    logic        hit;
    logic [2:0]  entry;
    logic [21:0] addr;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cfg(input logic [2:0] idx, input logic [1:0] fld, input logic [21:0] data);
    bus.cfg_we   = 1'b1;
    bus.cfg_idx  = idx;
    bus.cfg_fld  = fld;
    bus.cfg_data = data;
    @(posedge clk); #1;
    bus.cfg_we   = 1'b0;
  endtask

  // One request with rsp_ready high; lat counts edges from acceptance to rsp_valid.
  task automatic xact(input string nm, input logic [2:0] l, input logic [15:0] c,
                      output logic h, output logic [2:0] e, output logic [21:0] a,
                      output int lat);
    int n;
    bus.req_layer = l;
    bus.req_code  = c;
    bus.req_valid = 1'b1;
    #1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, ".accept"}, 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    h = bus.rsp_hit;
    e = bus.rsp_entry;
    a = bus.rsp_addr;
  endtask

  initial begin
    logic        h;
    logic [2:0]  e;
    logic [21:0] a;
    int          lat;
    int          k, got, cyc, seen;
    logic        rdy, rv, rr;
    logic [21:0] ra;

    bus.cfg_we    = 1'b0;
    bus.cfg_idx   = 3'd0;
    bus.cfg_fld   = 2'd0;
    bus.cfg_data  = '0;
    bus.req_valid = 1'b0;
    bus.req_layer = '0;
    bus.req_code  = '0;
    bus.rsp_ready = 1'b1;

    // Table: e0 SCROLL1 0..7FFF @020000, e1 OBJ|SCROLL1 0..FFFF @100000,
    // e2 inverted range (never hits), e3 STAR 0..FFFF @3FFFF0 (wraps).
    vecs[0]  = '{LAYER_SCROLL1, 16'h0010, 1'b1, 3'd0, 22'h020010};
    vecs[1]  = '{LAYER_SCROLL2, 16'h0010, 1'b0, 3'd0, 22'h000000};
    vecs[2]  = '{LAYER_SCROLL1, 16'h0005, 1'b1, 3'd0, 22'h020005};
    vecs[3]  = '{LAYER_OBJ,     16'h0005, 1'b1, 3'd1, 22'h100005};
    vecs[4]  = '{LAYER_SCROLL1, 16'h7FFF, 1'b1, 3'd0, 22'h027FFF};
    vecs[5]  = '{LAYER_SCROLL1, 16'h8000, 1'b1, 3'd1, 22'h108000};
    vecs[6]  = '{LAYER_OBJ,     16'hFFFF, 1'b1, 3'd1, 22'h10FFFF};
    vecs[7]  = '{LAYER_SCROLL3, 16'h0007, 1'b0, 3'd0, 22'h000000};
    vecs[8]  = '{LAYER_STAR,    16'h0020, 1'b1, 3'd3, 22'h000010};
    vecs[9]  = '{LAYER_STAR,    16'hFFFF, 1'b1, 3'd3, 22'h00FFEF};
    vecs[10] = '{3'd5,          16'h0005, 1'b0, 3'd0, 22'h000000};
    vecs[11] = '{3'd7,          16'h0005, 1'b0, 3'd0, 22'h000000};
    vecs[12] = '{LAYER_SCROLL2, 16'h0008, 1'b0, 3'd0, 22'h000000};

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst.rsp_addr",  32'(bus.rsp_addr),  32'd0);
    chk("rst.rsp_hit",   32'(bus.rsp_hit),   32'd0);
    chk("rst.rsp_entry", 32'(bus.rsp_entry), 32'd0);
    chk("rst.req_ready", 32'(bus.req_ready), 32'd1);

    xact("empty", LAYER_SCROLL1, 16'h0123, h, e, a, lat);
    chk("empty.lat",  32'(lat), 32'd2);
    chk("empty.hit",  32'(h),   32'd0);
    chk("empty.addr", 32'(a),   32'd0);

    cfg(3'd0, FLD_START, 22'h000000); cfg(3'd0, FLD_END, 22'h007FFF);
    cfg(3'd0, FLD_BASE,  22'h020000); cfg(3'd0, FLD_MASK, 22'h000022);
    cfg(3'd1, FLD_START, 22'h000000); cfg(3'd1, FLD_END, 22'h00FFFF);
    cfg(3'd1, FLD_BASE,  22'h100000); cfg(3'd1, FLD_MASK, 22'h000023);
    cfg(3'd2, FLD_START, 22'h000010); cfg(3'd2, FLD_END, 22'h000005);
    cfg(3'd2, FLD_BASE,  22'h200000); cfg(3'd2, FLD_MASK, 22'h00003F);
    cfg(3'd3, FLD_START, 22'h000000); cfg(3'd3, FLD_END, 22'h00FFFF);
    cfg(3'd3, FLD_BASE,  22'h3FFFF0); cfg(3'd3, FLD_MASK, 22'h000030);
    // Out-of-range index: must not create a catch-all entry.
    cfg(3'd4, FLD_START, 22'h000000); cfg(3'd4, FLD_END, 22'h00FFFF);
    cfg(3'd4, FLD_BASE,  22'h000100); cfg(3'd4, FLD_MASK, 22'h00003F);

    for (int i = 0; i < 13; i++) begin
      xact($sformatf("v%0d", i), vecs[i].layer, vecs[i].code, h, e, a, lat);
      chk($sformatf("v%0d.lat", i),   32'(lat), 32'd2);
      chk($sformatf("v%0d.hit", i),   32'(h),   32'(vecs[i].hit));
      chk($sformatf("v%0d.entry", i), 32'(e),   32'(vecs[i].entry));
      chk($sformatf("v%0d.addr", i),  32'(a),   32'(vecs[i].addr));
    end

    // Backpressure: four OBJ requests, consumer stalled for the first cycles.
    @(posedge clk); #1;
    k = 0; got = 0; cyc = 0;
    while (got < 4 && cyc < 40) begin
      bus.rsp_ready = (cyc > 5);
      bus.req_valid = (k < 4);
      bus.req_layer = LAYER_OBJ;
      bus.req_code  = 16'h0100 + 16'(k);
      #1;
      if (cyc == 2) chk("bp.addr_c2", 32'(bus.rsp_addr), 32'h100100);
      if (cyc == 5) begin
        chk("bp.accepted",  32'(k),             32'd2);
        chk("bp.req_ready", 32'(bus.req_ready), 32'd0);
        chk("bp.rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("bp.addr_c5",   32'(bus.rsp_addr),  32'h100100);
      end
      rdy = bus.req_ready; rv = bus.rsp_valid; rr = bus.rsp_ready; ra = bus.rsp_addr;
      @(posedge clk); #1;
      if (bus.req_valid && rdy) k++;
      if (rv && rr) begin
        chk($sformatf("bp.order%0d", got), 32'(ra), 32'h100100 + 32'(got));
        got++;
      end
      cyc++;
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    chk("bp.count", 32'(got), 32'd4);

    // Base rewritten in the acceptance cycle: old base for this request.
    @(posedge clk); #1;
    bus.cfg_we    = 1'b1;
    bus.cfg_idx   = 3'd0;
    bus.cfg_fld   = FLD_BASE;
    bus.cfg_data  = 22'h030000;
    bus.req_layer = LAYER_SCROLL1;
    bus.req_code  = 16'h0010;
    bus.req_valid = 1'b1;
    #1;
    chk("snap.req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.cfg_we    = 1'b0;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("snap.lat",  32'(lat),          32'd2);
    chk("snap.old",  32'(bus.rsp_addr), 32'h020010);
    xact("snap2", LAYER_SCROLL1, 16'h0010, h, e, a, lat);
    chk("snap.new",  32'(a), 32'h030010);

    // Fill both stages, then reset: nothing may come out afterwards.
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req_layer = LAYER_OBJ;
    bus.req_code  = 16'h0200;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("mid.full", 32'(bus.rsp_valid), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    chk("mid.req_ready", 32'(bus.req_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.rsp_valid) seen++;
      @(posedge clk); #1;
    end
    chk("mid.no_rsp", 32'(seen), 32'd0);
    xact("cleared", LAYER_SCROLL1, 16'h0010, h, e, a, lat);
    chk("cleared.hit",  32'(h), 32'd0);
    chk("cleared.addr", 32'(a), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
